// File: rtl/ahb_lite_master_ctrl.sv
// Purpose : AHB-Lite single-transfer master; turns a valid/ready request stream into pipelined NONSEQ transfers.
// Latency : request accepted at edge t -> NONSEQ in t+1, data phase t+2, RSP_VALID in t+3 (+1 per wait state).
// Backpressure: REQ_READY follows HREADY combinationally and drops during the ERROR sequence; responses have no backpressure.
//
// Ports:
//   HCLK, HRESETn                  clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY            request handshake
//   REQ_WRITE/ADDR/SIZE/WDATA      request payload (size 0/1/2, lane-placed write data)
//   RSP_VALID/RSP_RDATA/RSP_ERR    one-cycle in-order response pulse
//   BUSY                           a transfer is in its address or data phase
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA   AHB-Lite master outputs
//   HRDATA/HREADY/HRESP            AHB-Lite slave returns

module ahb_lite_master_ctrl (
   input  logic        HCLK,
   input  logic        HRESETn,
   // request stream
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WRITE,
   input  logic [31:0] REQ_ADDR,
   input  logic [2:0]  REQ_SIZE,
   input  logic [31:0] REQ_WDATA,
   // response stream
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic        BUSY,
   // AHB-Lite master side
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // Address-phase stage (A)
   logic        r_a_vld;
   logic [31:0] r_a_addr;
   logic        r_a_write;
   logic [2:0]  r_a_size;
   logic [31:0] r_a_wdata;

   // Data-phase stage (D)
   logic        r_d_vld;
   logic        r_d_write;
   logic [31:0] r_d_wdata;

   // Error sequencing
   logic        r_err1;         // first ERROR cycle seen, waiting for the second
   logic        r_cancel_pend;  // a request was pulled out of A and still owes a response
   logic        r_cancel_sent;  // its response has been registered; release intake next edge

   // Response registers
   logic        r_rsp_vld;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic        w_req_rdy;
   logic        w_accept;
   logic        w_err_first;
   logic        w_cancel_emit;

   // Intake stalls on wait states and stays closed for the whole error/cancel
   // sequence, so nothing new can overtake the cancelled request's response.
   assign w_req_rdy     = HREADY & ~r_err1 & ~r_cancel_pend;
   assign w_accept      = REQ_VALID & w_req_rdy;

   // First cycle of the two-cycle ERROR response.
   assign w_err_first   = r_d_vld & HRESP & ~HREADY;

   // The cancelled request is reported once the errored transfer has drained
   // out of D, i.e. the cycle after the errored response is registered.
   assign w_cancel_emit = r_cancel_pend & ~r_cancel_sent & ~r_err1 & ~r_d_vld;

   // ------------------------------------------------------------------
   // Address phase register
   // ------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_a_vld   <= 1'b0;
         r_a_addr  <= 32'd0;
         r_a_write <= 1'b0;
         r_a_size  <= 3'd0;
         r_a_wdata <= 32'd0;
      end else if (HREADY) begin
         if (w_accept) begin
            r_a_vld   <= 1'b1;
            r_a_addr  <= REQ_ADDR;
            r_a_write <= REQ_WRITE;
            r_a_size  <= REQ_SIZE;
            r_a_wdata <= REQ_WDATA;
         end else begin
            // Address/control are left as-is so the bus does not toggle while idle.
            r_a_vld <= 1'b0;
         end
      end else if (w_err_first) begin
         // Withdraw the pending address phase so the second error cycle is IDLE.
         r_a_vld <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Data phase register
   // ------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_d_vld   <= 1'b0;
         r_d_write <= 1'b0;
         r_d_wdata <= 32'd0;
      end else if (HREADY) begin
         r_d_vld   <= r_a_vld;
         r_d_write <= r_a_write;
         r_d_wdata <= r_a_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Error / cancel sequencing
   // ------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_err1        <= 1'b0;
         r_cancel_pend <= 1'b0;
         r_cancel_sent <= 1'b0;
      end else begin
         if (HREADY) begin
            // Second error cycle (or any normal completion) closes ERR1.
            r_err1 <= 1'b0;
         end else if (w_err_first) begin
            r_err1 <= 1'b1;
            if (r_a_vld) begin
               r_cancel_pend <= 1'b1;
            end
         end

         if (w_cancel_emit) begin
            r_cancel_sent <= 1'b1;
         end else if (r_cancel_sent) begin
            // Intake reopens only after the cancel response cycle has passed.
            r_cancel_pend <= 1'b0;
            r_cancel_sent <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response generation
   // ------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_rsp_vld   <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_vld   <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
         if (HREADY && r_d_vld) begin
            // HRESP with HREADY high completes D; without a preceding first
            // error cycle this is a slave violation but is still reported.
            r_rsp_vld <= 1'b1;
            r_rsp_err <= HRESP;
            if (!r_d_write && !HRESP) begin
               r_rsp_rdata <= HRDATA;
            end
         end else if (w_cancel_emit) begin
            r_rsp_vld <= 1'b1;
            r_rsp_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign REQ_READY = w_req_rdy;
   assign RSP_VALID = r_rsp_vld;
   assign RSP_RDATA = r_rsp_rdata;
   assign RSP_ERR   = r_rsp_err;
   assign BUSY      = r_a_vld | r_d_vld;

   assign HADDR     = r_a_addr;
   assign HWRITE    = r_a_write;
   assign HSIZE     = r_a_size;
   assign HTRANS    = r_a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HBURST    = HBURST_SINGLE;
   assign HWDATA    = (r_d_vld && r_d_write) ? r_d_wdata : 32'd0;

endmodule

// File: tb/tb_ahb_lite_master_ctrl.sv
// Purpose : directed bench for ahb_lite_master_ctrl: cycle table plus hand sequences for waits, errors and reset.
// Latency : inputs driven 1 time unit after each rising edge, outputs compared 4 units later (mid-cycle).
// Backpressure: slave behaviour (HREADY/HRESP/HRDATA) is scripted per cycle.

module tb_ahb_lite_master_ctrl;

   logic        HCLK;
   logic        HRESETn;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WRITE;
   logic [31:0] REQ_ADDR;
   logic [2:0]  REQ_SIZE;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        BUSY;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int n_pass  = 0;
   int n_total = 0;

   ahb_lite_master_ctrl dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_WRITE (REQ_WRITE),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_SIZE  (REQ_SIZE),
      .REQ_WDATA (REQ_WDATA),
      .RSP_VALID (RSP_VALID),
      .RSP_RDATA (RSP_RDATA),
      .RSP_ERR   (RSP_ERR),
      .BUSY      (BUSY),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        vld;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        hrdy;
      logic        hresp;
      logic [31:0] hrd;
      logic        e_rdy;
      logic [1:0]  e_trans;
      logic [31:0] e_addr;
      logic        e_wr;
      logic [31:0] e_wdata;
      logic        e_rspv;
      logic        e_err;
      logic [31:0] e_rdata;
      logic        e_busy;
   } vec_t;

   localparam int NVEC = 21;
   vec_t tbl [NVEC];

   function automatic vec_t mk(
      input logic vld, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
      input logic hrdy, input logic hresp, input logic [31:0] hrd,
      input logic e_rdy, input logic [1:0] e_trans, input logic [31:0] e_addr, input logic e_wr,
      input logic [31:0] e_wdata, input logic e_rspv, input logic e_err, input logic [31:0] e_rdata,
      input logic e_busy);
      vec_t v;
      v.vld = vld;  v.wr = wr;  v.addr = addr;  v.wd = wd;
      v.hrdy = hrdy;  v.hresp = hresp;  v.hrd = hrd;
      v.e_rdy = e_rdy;  v.e_trans = e_trans;  v.e_addr = e_addr;  v.e_wr = e_wr;
      v.e_wdata = e_wdata;  v.e_rspv = e_rspv;  v.e_err = e_err;  v.e_rdata = e_rdata;
      v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drv(input logic v, input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic rdy, input logic rsp, input logic [31:0] rd);
      REQ_VALID = v;  REQ_WRITE = w;  REQ_ADDR = a;  REQ_SIZE = sz;  REQ_WDATA = wd;
      HREADY = rdy;  HRESP = rsp;  HRDATA = rd;
   endtask

   task automatic idle_cyc(input logic [31:0] rd);
      drv(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0, rd);
   endtask

   task automatic adv();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " HTRANS"}, {30'd0, HTRANS}, 32'd0);
      chk({tag, " HADDR"},  HADDR, 32'd0);
      chk({tag, " HWRITE"}, {31'd0, HWRITE}, 32'd0);
      chk({tag, " HSIZE"},  {29'd0, HSIZE}, 32'd0);
      chk({tag, " HBURST"}, {29'd0, HBURST}, 32'd0);
      chk({tag, " HWDATA"}, HWDATA, 32'd0);
      chk({tag, " RSP_VALID"}, {31'd0, RSP_VALID}, 32'd0);
      chk({tag, " RSP_RDATA"}, RSP_RDATA, 32'd0);
      chk({tag, " RSP_ERR"}, {31'd0, RSP_ERR}, 32'd0);
      chk({tag, " BUSY"}, {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- vector table ----------------
      // single write, zero waits
      tbl[0]  = mk(1,1,32'h1000_0004,32'hDEAD_BEEF,1,0,0,          1,0,0,0,0,                    0,0,0,0);
      tbl[1]  = mk(0,0,0,0,1,0,0,                                  1,2,32'h1000_0004,1,0,        0,0,0,1);
      tbl[2]  = mk(0,0,0,0,1,0,0,                                  1,0,0,0,32'hDEAD_BEEF,        0,0,0,1);
      tbl[3]  = mk(0,0,0,0,1,0,0,                                  1,0,0,0,0,                    1,0,0,0);
      tbl[4]  = mk(0,0,0,0,1,0,0,                                  1,0,0,0,0,                    0,0,0,0);
      // 4 writes then 4 reads back-to-back; junk HRDATA during write data phases
      tbl[5]  = mk(1,1,32'h200,32'hA000_0000,1,0,32'hBAD0_BAD0,    1,0,0,0,0,                    0,0,0,0);
      tbl[6]  = mk(1,1,32'h204,32'hA000_0001,1,0,32'hBAD0_BAD0,    1,2,32'h200,1,0,              0,0,0,1);
      tbl[7]  = mk(1,1,32'h208,32'hA000_0002,1,0,32'hBAD0_BAD0,    1,2,32'h204,1,32'hA000_0000,  0,0,0,1);
      tbl[8]  = mk(1,1,32'h20C,32'hA000_0003,1,0,32'hBAD0_BAD0,    1,2,32'h208,1,32'hA000_0001,  1,0,0,1);
      tbl[9]  = mk(1,0,32'h200,32'hFFFF_FFFF,1,0,32'hBAD0_BAD0,    1,2,32'h20C,1,32'hA000_0002,  1,0,0,1);
      tbl[10] = mk(1,0,32'h204,32'hFFFF_FFFF,1,0,32'hBAD0_BAD0,    1,2,32'h200,0,32'hA000_0003,  1,0,0,1);
      tbl[11] = mk(1,0,32'h208,32'hFFFF_FFFF,1,0,32'hC000_0000,    1,2,32'h204,0,0,              1,0,0,1);
      tbl[12] = mk(1,0,32'h20C,32'hFFFF_FFFF,1,0,32'hC000_0001,    1,2,32'h208,0,0,              1,0,32'hC000_0000,1);
      tbl[13] = mk(0,0,0,0,1,0,32'hC000_0002,                      1,2,32'h20C,0,0,              1,0,32'hC000_0001,1);
      tbl[14] = mk(0,0,0,0,1,0,32'hC000_0003,                      1,0,0,0,0,                    1,0,32'hC000_0002,1);
      tbl[15] = mk(0,0,0,0,1,0,0,                                  1,0,0,0,0,                    1,0,32'hC000_0003,0);
      tbl[16] = mk(0,0,0,0,1,0,0,                                  1,0,0,0,0,                    0,0,0,0);
      // single-cycle ERROR (HREADY high, no first cycle) on a read
      tbl[17] = mk(1,0,32'h800,0,1,0,0,                            1,0,0,0,0,                    0,0,0,0);
      tbl[18] = mk(0,0,0,0,1,0,0,                                  1,2,32'h800,0,0,              0,0,0,1);
      tbl[19] = mk(0,0,0,0,1,1,32'h9999_9999,                      1,0,0,0,0,                    0,0,0,1);
      tbl[20] = mk(0,0,0,0,1,0,0,                                  1,0,0,0,0,                    1,1,0,0);

      // ---------------- reset ----------------
      HRESETn = 1'b0;
      idle_cyc(32'd0);
      repeat (2) @(posedge HCLK);
      #1;
      chk_reset_outputs("reset");
      HRESETn = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < NVEC; i++) begin
         drv(tbl[i].vld, tbl[i].wr, tbl[i].addr, 3'd2, tbl[i].wd, tbl[i].hrdy, tbl[i].hresp, tbl[i].hrd);
         #4;
         chk($sformatf("vec%0d REQ_READY", i), {31'd0, REQ_READY}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("vec%0d HTRANS", i), {30'd0, HTRANS}, {30'd0, tbl[i].e_trans});
         chk($sformatf("vec%0d HWDATA", i), HWDATA, tbl[i].e_wdata);
         chk($sformatf("vec%0d HBURST", i), {29'd0, HBURST}, 32'd0);
         chk($sformatf("vec%0d RSP_VALID", i), {31'd0, RSP_VALID}, {31'd0, tbl[i].e_rspv});
         chk($sformatf("vec%0d BUSY", i), {31'd0, BUSY}, {31'd0, tbl[i].e_busy});
         if (tbl[i].e_trans == 2'b10) begin
            chk($sformatf("vec%0d HADDR", i), HADDR, tbl[i].e_addr);
            chk($sformatf("vec%0d HWRITE", i), {31'd0, HWRITE}, {31'd0, tbl[i].e_wr});
            chk($sformatf("vec%0d HSIZE", i), {29'd0, HSIZE}, 32'd2);
         end
         if (tbl[i].e_rspv) begin
            chk($sformatf("vec%0d RSP_ERR", i), {31'd0, RSP_ERR}, {31'd0, tbl[i].e_err});
            chk($sformatf("vec%0d RSP_RDATA", i), RSP_RDATA, tbl[i].e_rdata);
         end
         adv();
      end

      // ---------------- read with 2 wait states ----------------
      drv(1'b1, 1'b0, 32'h3000_0008, 3'd1, 32'd0, 1'b1, 1'b0, 32'd0);
      #4; chk("wait accept REQ_READY", {31'd0, REQ_READY}, 32'd1);
      adv();
      idle_cyc(32'd0);
      #4; chk("wait HTRANS nonseq", {30'd0, HTRANS}, 32'd2);
      chk("wait HADDR", HADDR, 32'h3000_0008);
      chk("wait HSIZE", {29'd0, HSIZE}, 32'd1);
      chk("wait HWRITE", {31'd0, HWRITE}, 32'd0);
      adv();
      for (int k = 0; k < 3; k++) begin
         drv(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, (k == 2), 1'b0, (k == 2) ? 32'h1234_5678 : 32'd0);
         #4;
         chk($sformatf("wait%0d HADDR held", k), HADDR, 32'h3000_0008);
         chk($sformatf("wait%0d HTRANS", k), {30'd0, HTRANS}, 32'd0);
         chk($sformatf("wait%0d RSP_VALID", k), {31'd0, RSP_VALID}, 32'd0);
         chk($sformatf("wait%0d BUSY", k), {31'd0, BUSY}, 32'd1);
         adv();
      end
      idle_cyc(32'd0);
      #4; chk("wait RSP_VALID", {31'd0, RSP_VALID}, 32'd1);
      chk("wait RSP_RDATA", RSP_RDATA, 32'h1234_5678);
      chk("wait RSP_ERR", {31'd0, RSP_ERR}, 32'd0);
      adv();

      // ---------------- two-cycle ERROR on read A, read B cancelled ----------------
      drv(1'b1, 1'b0, 32'h400, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      #4; chk("err accept A", {31'd0, REQ_READY}, 32'd1);
      adv();
      drv(1'b1, 1'b0, 32'h404, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      #4; chk("err A addr phase", HADDR, 32'h400);
      chk("err accept B", {31'd0, REQ_READY}, 32'd1);
      adv();
      // first error cycle; request C is offered from here on
      drv(1'b1, 1'b0, 32'h500, 3'd2, 32'd0, 1'b0, 1'b1, 32'd0);
      #4; chk("err1 HTRANS", {30'd0, HTRANS}, 32'd2);
      chk("err1 HADDR", HADDR, 32'h404);
      chk("err1 REQ_READY", {31'd0, REQ_READY}, 32'd0);
      adv();
      drv(1'b1, 1'b0, 32'h500, 3'd2, 32'd0, 1'b1, 1'b1, 32'hFFFF_0000);
      #4; chk("err2 HTRANS idle", {30'd0, HTRANS}, 32'd0);
      chk("err2 REQ_READY", {31'd0, REQ_READY}, 32'd0);
      chk("err2 RSP_VALID", {31'd0, RSP_VALID}, 32'd0);
      adv();
      drv(1'b1, 1'b0, 32'h500, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      #4; chk("errA RSP_VALID", {31'd0, RSP_VALID}, 32'd1);
      chk("errA RSP_ERR", {31'd0, RSP_ERR}, 32'd1);
      chk("errA RSP_RDATA", RSP_RDATA, 32'd0);
      chk("errA HTRANS", {30'd0, HTRANS}, 32'd0);
      chk("errA REQ_READY", {31'd0, REQ_READY}, 32'd0);
      adv();
      #4; chk("cancB RSP_VALID", {31'd0, RSP_VALID}, 32'd1);
      chk("cancB RSP_ERR", {31'd0, RSP_ERR}, 32'd1);
      chk("cancB RSP_RDATA", RSP_RDATA, 32'd0);
      chk("cancB HTRANS", {30'd0, HTRANS}, 32'd0);
      chk("cancB REQ_READY", {31'd0, REQ_READY}, 32'd0);
      adv();
      #4; chk("post RSP_VALID", {31'd0, RSP_VALID}, 32'd0);
      chk("post HTRANS", {30'd0, HTRANS}, 32'd0);
      chk("post REQ_READY", {31'd0, REQ_READY}, 32'd1);
      adv();
      idle_cyc(32'd0);
      #4; chk("C HTRANS", {30'd0, HTRANS}, 32'd2);
      chk("C HADDR", HADDR, 32'h500);
      adv();
      idle_cyc(32'hCAFE_F00D);
      #4; chk("C data HTRANS", {30'd0, HTRANS}, 32'd0);
      adv();
      idle_cyc(32'd0);
      #4; chk("C RSP_VALID", {31'd0, RSP_VALID}, 32'd1);
      chk("C RSP_ERR", {31'd0, RSP_ERR}, 32'd0);
      chk("C RSP_RDATA", RSP_RDATA, 32'hCAFE_F00D);
      adv();

      // ---------------- request held while HREADY low, A idle ----------------
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 1'b1, 32'h600, 3'd2, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'd0);
         #4;
         chk($sformatf("stall%0d REQ_READY", k), {31'd0, REQ_READY}, 32'd0);
         chk($sformatf("stall%0d HTRANS", k), {30'd0, HTRANS}, 32'd0);
         chk($sformatf("stall%0d HADDR", k), HADDR, 32'h500);
         chk($sformatf("stall%0d BUSY", k), {31'd0, BUSY}, 32'd0);
         adv();
      end
      drv(1'b1, 1'b1, 32'h600, 3'd2, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'd0);
      #4; chk("stall accept", {31'd0, REQ_READY}, 32'd1);
      adv();
      idle_cyc(32'd0);
      #4; chk("stall HTRANS", {30'd0, HTRANS}, 32'd2);
      chk("stall HADDR", HADDR, 32'h600);
      chk("stall HWRITE", {31'd0, HWRITE}, 32'd1);
      adv();
      #4; chk("stall HWDATA", HWDATA, 32'h5A5A_5A5A);
      adv();
      #4; chk("stall RSP_VALID", {31'd0, RSP_VALID}, 32'd1);
      chk("stall RSP_ERR", {31'd0, RSP_ERR}, 32'd0);
      adv();

      // ---------------- reset during a waited data phase ----------------
      drv(1'b1, 1'b1, 32'h700, 3'd2, 32'h7777_7777, 1'b1, 1'b0, 32'd0);
      #4; chk("rst accept", {31'd0, REQ_READY}, 32'd1);
      adv();
      idle_cyc(32'd0);
      #4; chk("rst HTRANS", {30'd0, HTRANS}, 32'd2);
      adv();
      drv(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      #4; chk("rst HWDATA before", HWDATA, 32'h7777_7777);
      chk("rst BUSY before", {31'd0, BUSY}, 32'd1);
      #1; HRESETn = 1'b0;
      #1; chk_reset_outputs("midrst");
      adv();
      adv();
      HRESETn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         idle_cyc(32'd0);
         #4;
         chk($sformatf("afterrst%0d RSP_VALID", k), {31'd0, RSP_VALID}, 32'd0);
         chk($sformatf("afterrst%0d HTRANS", k), {30'd0, HTRANS}, 32'd0);
         adv();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
